mac_pe_v2: RTL and testbench
============================

// Module: mac_pe_v2
// PURPOSE
//  Parametrised, pipelined multiply-accumulate PE for the output-stationary systolic array.
//  Forwards operands down and right. Accumulates valid products into a wide accumulator.
//  On a group-last marker it emits one fixed-point-rounded result with a 1-cycle valid strobe.
//  Successor to the basic PE: adds signed mode, valid/last qualifiers, a wider accumulator,
//  rounding, reset and optional saturation.
// PARAMETERS
//  DATA_WIDTH  8   operand width (i_up, i_left)
//  ACC_WIDTH   24  accumulator and o_result width; must be >= 2*DATA_WIDTH
//  FRAC_BITS   4   result right-shift with round-half-up; 0 = no shift; must be < 2*DATA_WIDTH
//  SIGNED      1   1 = two's-complement operands and accumulator; 0 = unsigned
// PORTS
//  clk          in   1           single clock, rising edge
//  rst_n        in   1           asynchronous reset, active-low
//  i_valid      in   1           operand pair valid this cycle
//  i_last       in   1           final pair of the current group (qualified by i_valid)
//  i_up         in   DATA_WIDTH  operand from the north
//  i_left       in   DATA_WIDTH  operand from the west
//  o_down       out  DATA_WIDTH  i_up delayed 1 cycle
//  o_right      out  DATA_WIDTH  i_left delayed 1 cycle
//  o_valid      out  1           i_valid delayed 1 cycle (to neighbours)
//  o_last       out  1           i_last delayed 1 cycle (to neighbours)
//  o_res_valid  out  1           1-cycle strobe: o_result updated
//  o_result     out  ACC_WIDTH   rounded group result; held until the next strobe
// BEHAVIOUR
//  - Reset (rst_n=0, async): all outputs 0, accumulator 0, pipeline valids 0, first-flag 1.
//  - Forwarding: o_down/o_right/o_valid/o_last register their inputs every cycle,
//    unconditionally, including when i_valid=0.
//  - Stage 1, edge k:
//    - p <= i_up*i_left, full 2*DATA_WIDTH product.
//    - Signedness follows SIGNED.
//    - p_v <= i_valid; p_l <= i_valid & i_last.
//  - Stage 2, edge k+1, only if p_v:
//    - acc_nxt = (first ? 0 : acc) + ext(p), sign- or zero-extended to ACC_WIDTH.
//    - acc <= acc_nxt; first <= p_l.
//  - If p_v & p_l:
//    - o_result <= (acc_nxt + (FRAC_BITS ? 1<<(FRAC_BITS-1) : 0)) >>> FRAC_BITS.
//    - The shift is arithmetic if SIGNED, logical otherwise.
//    - o_res_valid <= 1; else o_res_valid <= 0.
//  - Latency: the last pair sampled at edge k gives o_res_valid high after edge k+1 (2 cycles).
//  - Bubbles (i_valid=0) leave acc, first and o_result unchanged.
//    i_last without i_valid is ignored for accumulation and still forwarded on o_last.
//  - Single-pair group (valid & last with first=1): result = rounded product.
//  - Back-to-back groups: a valid pair the cycle after a last starts from 0 with no lost cycle.
//  - Overflow (macro off): acc and the rounding add wrap modulo 2^ACC_WIDTH.
//  - Reset mid-group: the partial sum is discarded, no strobe is issued,
//    and the next valid pair starts a new group.
// CONFIGURATION
//  PE_SATURATE_EN defined:
//    - acc_nxt and the rounded result clamp to the ACC_WIDTH range instead of wrapping.
//    - Range: SIGNED=1 [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]; SIGNED=0 [0, 2^ACC_WIDTH-1].
//    - Once clamped, later terms accumulate from the clamped value.
//  PE_SATURATE_EN undefined: pure modulo wrap; no clamp logic is synthesised.
// TESTING
//  1 DW=8,ACC=24,FRAC=0,SIGNED=1: (3,4),(-2,5),(7,-1) with last on the 3rd
//    -> o_result=-5, o_res_valid high exactly 2 cycles after the 3rd pair, for 1 cycle.
//  2 FRAC=4, single-pair groups: (8,1) -> o_result=1; (7,1) -> 0; SIGNED=1 (-8,1) -> 0;
//    (-9,1) -> -1.
//  3 ACC=16,SIGNED=1: (127,127) x3, last on the 3rd
//    -> macro on: 32767; macro off: -17149 (48387 wrapped).
//  4 Group (2,3)+(4,5) last, immediately followed by group (1,1) last
//    -> strobes on consecutive cycles with o_result 26 then 1; bubbles inserted between pairs
//    give the same values.
//  5 Pulse rst_n=0 after 2 pairs of a group, then send (6,6) last
//    -> no strobe for the aborted group; o_result=36; all outputs 0 during reset.
//  6 Random 1000-pair stream with random i_valid
//    -> o_down/o_right/o_valid/o_last equal the inputs delayed exactly 1 cycle;
//    results match the reference model.

Source files
------------

// File: rtl/mac_pe_v2.sv
// mac_pe_v2: pipelined multiply-accumulate PE for an output-stationary systolic array.
// Latency: operands/qualifiers forwarded after 1 cycle; group result strobed 2 cycles after the last pair.
// Backpressure: none; a pair is accepted every cycle, i_valid=0 cycles are bubbles.
// Build option: define PE_SATURATE_EN to clamp accumulation and rounding instead of wrapping.

module mac_pe_v2 #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int FRAC_BITS  = 4,
    parameter int SIGNED     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_valid,
    input  logic                  i_last,
    input  logic [DATA_WIDTH-1:0] i_up,
    input  logic [DATA_WIDTH-1:0] i_left,
    output logic [DATA_WIDTH-1:0] o_down,
    output logic [DATA_WIDTH-1:0] o_right,
    output logic                  o_valid,
    output logic                  o_last,
    output logic                  o_res_valid,
    output logic [ACC_WIDTH-1:0]  o_result
);

    localparam int PW = 2 * DATA_WIDTH;
    // Half an output LSB, added before the right shift for round-half-up.
    localparam logic [ACC_WIDTH-1:0] RND = ACC_WIDTH'((1 << FRAC_BITS) >> 1);

    logic [PW-1:0]               op_a, op_b, p;
    logic                        p_v, p_l, first;
    logic [ACC_WIDTH-1:0]        acc, acc_base, p_fill, p_ext, acc_nxt;
    logic [ACC_WIDTH-1:0]        rnd_sum, shr_u, res_nxt;
    logic signed [ACC_WIDTH-1:0] rnd_s, shr_s;

    // Extend operands to product width so one multiplier's low half serves both modes.
    always_comb begin
        if (SIGNED != 0) begin
            op_a = {{DATA_WIDTH{i_up[DATA_WIDTH-1]}}, i_up};
            op_b = {{DATA_WIDTH{i_left[DATA_WIDTH-1]}}, i_left};
        end else begin
            op_a = {{DATA_WIDTH{1'b0}}, i_up};
            op_b = {{DATA_WIDTH{1'b0}}, i_left};
        end
    end

    // Neighbour forwarding: unconditional one-cycle delay of every operand and qualifier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_down  <= '0;
            o_right <= '0;
            o_valid <= 1'b0;
            o_last  <= 1'b0;
        end else begin
            o_down  <= i_up;
            o_right <= i_left;
            o_valid <= i_valid;
            o_last  <= i_last;
        end
    end

    // Stage 1: register the full-width product and its qualifiers (last only counts when valid).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p   <= '0;
            p_v <= 1'b0;
            p_l <= 1'b0;
        end else begin
            p   <= op_a * op_b;
            p_v <= i_valid;
            p_l <= i_valid & i_last;
        end
    end

    // Sign- or zero-extend the product; the fill mask is empty when ACC_WIDTH equals the product width.
    assign p_fill   = (SIGNED != 0 && p[PW-1]) ? ({ACC_WIDTH{1'b1}} << PW) : '0;
    assign p_ext    = ACC_WIDTH'(p) | p_fill;
    // The first pair of a group starts from zero rather than the stale accumulator.
    assign acc_base = first ? '0 : acc;

`ifdef PE_SATURATE_EN
    localparam logic [ACC_WIDTH-1:0] S_MAX = (SIGNED != 0) ? {1'b0, {(ACC_WIDTH-1){1'b1}}} : '1;
    localparam logic [ACC_WIDTH-1:0] S_MIN = (SIGNED != 0) ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : '0;

    logic [ACC_WIDTH:0] acc_wide, rnd_wide;

    // One guard bit exposes overflow of the accumulate and rounding adds; clamp on overflow.
    always_comb begin
        if (SIGNED != 0) begin
            acc_wide = {acc_base[ACC_WIDTH-1], acc_base} + {p_ext[ACC_WIDTH-1], p_ext};
        end else begin
            acc_wide = {1'b0, acc_base} + {1'b0, p_ext};
        end
        acc_nxt = acc_wide[ACC_WIDTH-1:0];
        if (SIGNED != 0) begin
            if (acc_wide[ACC_WIDTH] != acc_wide[ACC_WIDTH-1]) acc_nxt = acc_wide[ACC_WIDTH] ? S_MIN : S_MAX;
        end else if (acc_wide[ACC_WIDTH]) begin
            acc_nxt = S_MAX;
        end

        if (SIGNED != 0) begin
            rnd_wide = {acc_nxt[ACC_WIDTH-1], acc_nxt} + {1'b0, RND};
        end else begin
            rnd_wide = {1'b0, acc_nxt} + {1'b0, RND};
        end
        rnd_sum = rnd_wide[ACC_WIDTH-1:0];
        if (SIGNED != 0) begin
            if (rnd_wide[ACC_WIDTH] != rnd_wide[ACC_WIDTH-1]) rnd_sum = rnd_wide[ACC_WIDTH] ? S_MIN : S_MAX;
        end else if (rnd_wide[ACC_WIDTH]) begin
            rnd_sum = S_MAX;
        end
    end
`else
    // Plain modulo arithmetic at accumulator width.
    assign acc_nxt = acc_base + p_ext;
    assign rnd_sum = acc_nxt + RND;
`endif

    // Separate signed net so the arithmetic shift is not demoted to logical by mixed-sign context.
    assign rnd_s   = rnd_sum;
    assign shr_s   = rnd_s >>> FRAC_BITS;
    assign shr_u   = rnd_sum >> FRAC_BITS;
    assign res_nxt = (SIGNED != 0) ? shr_s : shr_u;

    // Stage 2: accumulate valid products; on group-last publish the rounded result for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '0;
            first       <= 1'b1;
            o_result    <= '0;
            o_res_valid <= 1'b0;
        end else begin
            o_res_valid <= p_v & p_l;
            if (p_v) begin
                acc   <= acc_nxt;
                first <= p_l;
                if (p_l) o_result <= res_nxt;
            end
        end
    end

endmodule

// File: tb/tb_mac_pe_v2.sv
// tb_mac_pe_v2: four differently parameterised PEs share one stimulus stream.
// Latency: each bench cycle drives a pair, then compares every output one step after the edge.
// Backpressure: not applicable; the DUT never stalls.

module tb_mac_pe_v2;

`ifdef PE_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_valid = 1'b0, i_last = 1'b0;
    logic [7:0] i_up = '0, i_left = '0;

    logic [7:0]  dn [4];
    logic [7:0]  rt [4];
    logic        ov [4];
    logic        ol [4];
    logic        rv [4];
    logic [63:0] rs [4];
    logic [23:0] r0, r1, r3;
    logic [15:0] r2;

    int checks = 0, failures = 0, cyc_n = 0;

    // Per-instance configuration mirrored from the instantiations below.
    int C_ACC [4] = '{24, 24, 16, 24};
    int C_FR  [4] = '{0, 4, 0, 3};
    bit C_SG  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

    // Reference state: group sum as a plain integer, expected strobe/result.
    longint      m_acc [4];
    bit          m_first [4];
    logic [63:0] e_res [4];
    bit          e_rv [4];
    bit          pv, pl;
    logic [7:0]  pa, pb;

    logic [63:0] gq [4][$];
    int          gc [4][$];

    always #5 clk = ~clk;

    mac_pe_v2 #(.DATA_WIDTH(8), .ACC_WIDTH(24), .FRAC_BITS(0), .SIGNED(1)) u0 (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_last(i_last), .i_up(i_up), .i_left(i_left),
        .o_down(dn[0]), .o_right(rt[0]), .o_valid(ov[0]), .o_last(ol[0]), .o_res_valid(rv[0]), .o_result(r0));
    mac_pe_v2 #(.DATA_WIDTH(8), .ACC_WIDTH(24), .FRAC_BITS(4), .SIGNED(1)) u1 (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_last(i_last), .i_up(i_up), .i_left(i_left),
        .o_down(dn[1]), .o_right(rt[1]), .o_valid(ov[1]), .o_last(ol[1]), .o_res_valid(rv[1]), .o_result(r1));
    mac_pe_v2 #(.DATA_WIDTH(8), .ACC_WIDTH(16), .FRAC_BITS(0), .SIGNED(1)) u2 (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_last(i_last), .i_up(i_up), .i_left(i_left),
        .o_down(dn[2]), .o_right(rt[2]), .o_valid(ov[2]), .o_last(ol[2]), .o_res_valid(rv[2]), .o_result(r2));
    mac_pe_v2 #(.DATA_WIDTH(8), .ACC_WIDTH(24), .FRAC_BITS(3), .SIGNED(0)) u3 (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_last(i_last), .i_up(i_up), .i_left(i_left),
        .o_down(dn[3]), .o_right(rt[3]), .o_valid(ov[3]), .o_last(ol[3]), .o_res_valid(rv[3]), .o_result(r3));

    // Widen results so one comparison path serves every instance.
    always_comb begin
        rs[0] = 64'(r0);
        rs[1] = 64'(r1);
        rs[2] = 64'(r2);
        rs[3] = 64'(r3);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_n);
        end
    endtask

    // Bring an integer into the accumulator range: clamp when saturating, else wrap.
    function automatic longint fit(input longint x, input int w, input bit sg);
        longint m, y;
        m = longint'(1) << w;
        if (SAT) begin
            if (sg) begin
                y = (x > m / 2 - 1) ? m / 2 - 1 : ((x < -(m / 2)) ? -(m / 2) : x);
            end else begin
                y = (x > m - 1) ? m - 1 : ((x < 0) ? 0 : x);
            end
        end else begin
            y = x % m;
            if (y < 0) y += m;
            if (sg && y >= m / 2) y -= m;
        end
        return y;
    endfunction

    // Apply the pair sampled one edge earlier to every instance's reference.
    task automatic model_edge();
        longint a, b, s, r;
        for (int i = 0; i < 4; i++) begin
            e_rv[i] = 1'b0;
            if (pv) begin
                if (C_SG[i]) begin
                    a = $signed(pa);
                    b = $signed(pb);
                end else begin
                    a = pa;
                    b = pb;
                end
                s = fit((m_first[i] ? 64'sd0 : m_acc[i]) + a * b, C_ACC[i], C_SG[i]);
                m_acc[i]   = s;
                m_first[i] = pl;
                if (pl) begin
                    r = fit(s + ((longint'(1) << C_FR[i]) >> 1), C_ACC[i], C_SG[i]);
                    r = r >>> C_FR[i];
                    e_res[i] = r & ((longint'(1) << C_ACC[i]) - 1);
                    e_rv[i]  = 1'b1;
                end
            end
        end
    endtask

    task automatic cyc(input bit v, input bit l, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        i_valid = v; i_last = l; i_up = a; i_left = b;
        @(posedge clk);
        #1;
        cyc_n++;
        model_edge();
        pv = v; pl = v & l; pa = a; pb = b;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("u%0d_down", i), 64'(dn[i]), 64'(a));
            chk($sformatf("u%0d_right", i), 64'(rt[i]), 64'(b));
            chk($sformatf("u%0d_valid", i), 64'(ov[i]), 64'(v));
            chk($sformatf("u%0d_last", i), 64'(ol[i]), 64'(l));
            chk($sformatf("u%0d_res_valid", i), 64'(rv[i]), 64'(e_rv[i]));
            chk($sformatf("u%0d_result", i), rs[i], e_res[i]);
            if (rv[i]) begin
                gq[i].push_back(rs[i]);
                gc[i].push_back(cyc_n);
            end
        end
    endtask

    task automatic bubbles(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic chk_zero(input string tag);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_u%0d_fwd", tag, i), {dn[i], rt[i], 6'b0, ov[i], ol[i]}, 64'd0);
            chk($sformatf("%s_u%0d_res", tag, i), {rs[i][62:0], rv[i]}, 64'd0);
        end
    endtask

    // Reset with busy inputs: outputs must drop immediately and stay low across edges.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        i_valid = 1'b1; i_last = 1'b1; i_up = 8'hA5; i_left = 8'h5A;
        #1;
        chk_zero("rst_async");
        repeat (2) @(posedge clk);
        #1;
        chk_zero("rst_hold");
        for (int i = 0; i < 4; i++) begin
            m_acc[i] = 0; m_first[i] = 1'b1; e_res[i] = '0; e_rv[i] = 1'b0;
        end
        pv = 1'b0; pl = 1'b0;
        @(negedge clk);
        i_valid = 1'b0; i_last = 1'b0; i_up = '0; i_left = '0;
        rst_n = 1'b1;
    endtask

    function automatic logic [63:0] qget(input int i, input int j);
        if (j < gq[i].size()) return gq[i][j];
        return 64'hDEAD_BEEF_DEAD_BEEF;
    endfunction

    function automatic int cget(input int i, input int j);
        if (j < gc[i].size()) return gc[i][j];
        return -100;
    endfunction

    task automatic clear_q();
        for (int i = 0; i < 4; i++) begin
            gq[i].delete();
            gc[i].delete();
        end
    endtask

    initial begin
        int k;
        do_reset();

        // Signed accumulate, exact strobe timing.
        clear_q();
        cyc(1'b1, 1'b0, 8'd3, 8'd4);
        cyc(1'b1, 1'b0, 8'hFE, 8'd5);
        cyc(1'b1, 1'b1, 8'd7, 8'hFF);
        k = cyc_n;
        bubbles(3);
        chk("t1_count", 64'(gq[0].size()), 64'd1);
        chk("t1_value", qget(0, 0), 64'hFF_FFFB);
        chk("t1_timing", 64'(cget(0, 0)), 64'(k + 1));

        // Round-half-up on single-pair groups.
        clear_q();
        cyc(1'b1, 1'b1, 8'd8, 8'd1);
        cyc(1'b1, 1'b1, 8'd7, 8'd1);
        cyc(1'b1, 1'b1, 8'hF8, 8'd1);
        cyc(1'b1, 1'b1, 8'hF7, 8'd1);
        bubbles(2);
        chk("t2_count", 64'(gq[1].size()), 64'd4);
        chk("t2_8", qget(1, 0), 64'd1);
        chk("t2_7", qget(1, 1), 64'd0);
        chk("t2_m8", qget(1, 2), 64'd0);
        chk("t2_m9", qget(1, 3), 64'hFF_FFFF);

        // Overflow of a 16-bit accumulator.
        clear_q();
        cyc(1'b1, 1'b0, 8'd127, 8'd127);
        cyc(1'b1, 1'b0, 8'd127, 8'd127);
        cyc(1'b1, 1'b1, 8'd127, 8'd127);
        bubbles(2);
        chk("t3_value", qget(2, 0), SAT ? 64'h7FFF : 64'hBD03);

        // Back-to-back groups, then the same groups with bubbles and a stray last.
        clear_q();
        cyc(1'b1, 1'b0, 8'd2, 8'd3);
        cyc(1'b1, 1'b1, 8'd4, 8'd5);
        cyc(1'b1, 1'b1, 8'd1, 8'd1);
        bubbles(2);
        chk("t4_first", qget(0, 0), 64'd26);
        chk("t4_second", qget(0, 1), 64'd1);
        chk("t4_gap", 64'(cget(0, 1) - cget(0, 0)), 64'd1);
        clear_q();
        cyc(1'b1, 1'b0, 8'd2, 8'd3);
        bubbles(1);
        cyc(1'b0, 1'b1, 8'd9, 8'd9);
        cyc(1'b1, 1'b1, 8'd4, 8'd5);
        bubbles(2);
        cyc(1'b1, 1'b1, 8'd1, 8'd1);
        bubbles(2);
        chk("t4b_count", 64'(gq[0].size()), 64'd2);
        chk("t4b_first", qget(0, 0), 64'd26);
        chk("t4b_second", qget(0, 1), 64'd1);

        // Reset in the middle of a group discards it.
        clear_q();
        cyc(1'b1, 1'b0, 8'd1, 8'd2);
        cyc(1'b1, 1'b0, 8'd3, 8'd4);
        do_reset();
        cyc(1'b1, 1'b1, 8'd6, 8'd6);
        bubbles(2);
        chk("t5_count", 64'(gq[0].size()), 64'd1);
        chk("t5_value", qget(0, 0), 64'd36);

        // Random stream against the reference model.
        clear_q();
        for (int n = 0; n < 1000; n++) begin
            cyc($urandom_range(0, 9) < 7, $urandom_range(0, 4) == 0,
                8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end
        bubbles(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
